// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and default frame constants
package uart_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser (clk, rst active-low sync, d async in, q synced out) resetting to RST_VAL
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] m;
  always_ff @(posedge clk) {q, m} <= !rst ? {RST_VAL, RST_VAL} : {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver on os_tick oversampling (clk, rst active-low sync, os_tick, rx in; rx_data, rx_valid, frame_err, busy out)
module uart_rx import uart_pkg::*; #(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  logic [1:0] state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic armed, rx_s;
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      armed     <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (os_tick) begin
        tick_cnt <= tick_cnt == T_END ? '0 : tick_cnt + 1'b1;
        case (state)
          ST_IDLE: begin
            tick_cnt <= '0;
            if (rx_s) armed <= 1'b1;
            else if (armed) state <= ST_START;
          end
          ST_START: if (tick_cnt == T_MID) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? ST_IDLE : ST_DATA;
          end
          ST_DATA: if (tick_cnt == T_END) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == B_LAST) state <= ST_STOP;
          end
          default: if (tick_cnt == T_END) begin
            rx_valid  <= rx_s;
            frame_err <= !rx_s;
            if (rx_s) rx_data <= shreg;
            else armed <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed 8N1 frames
module tb_uart_rx;
  localparam int DIV = 5;
  localparam int OS  = 16;
  localparam int BIT = OS * DIV;
  typedef struct packed {logic err; logic [7:0] data;} exp_t;
  logic clk = 0, rst = 0, os_tick = 0, rx = 1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, busy;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, pushed = 0, seen = 0;
  logic prev_pulse = 0, prev_busy = 0, chk_busy = 0;
  uart_rx dut (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );
  always #10 clk = ~clk;
  initial forever begin
    repeat (DIV - 1) @(negedge clk);
    os_tick = 1;
    @(negedge clk);
    os_tick = 0;
  end
  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic err, input logic [7:0] data);
    sb.push_back({err, data});
    pushed++;
  endtask
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask
  task automatic idle(input int bits);
    rx = 1;
    repeat (bits * BIT) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (chk_busy) begin
      check("busy_after_pulse", busy, 0);
      chk_busy = 0;
    end
    if (rx_valid || frame_err) begin
      seen++;
      check("pulse_exclusive", rx_valid && frame_err, 0);
      check("pulse_width", prev_pulse, 0);
      check("busy_before_pulse", prev_busy, 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%0h expected no pulse", rx_valid, frame_err, rx_data);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_err", frame_err, mon_e.err);
        check("rx_data", rx_data, mon_e.data);
      end
      chk_busy = 1;
    end
    prev_pulse = rx_valid || frame_err;
    prev_busy  = busy;
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1;
    idle(1);
    push(0, 8'h55);
    send(8'h55, 1);
    idle(2);
    n = 0;
    rx = 0;
    for (int i = 0; i < 4 * DIV + 2 * BIT; i++) begin
      if (i == 4 * DIV) rx = 1;
      @(negedge clk);
      n += int'(busy);
    end
    check("glitch_busy_seen", n > 0, 1);
    check("glitch_busy_short", n < BIT, 1);
    push(0, 8'h55);
    send(8'h55, 1);
    push(1, 8'h55);
    send(8'hA3, 0);
    idle(2);
    check("err_hold_data", rx_data, 8'h55);
    push(0, 8'h00);
    push(0, 8'hFF);
    send(8'h00, 1);
    send(8'hFF, 1);
    idle(2);
    send_bit(0);
    send_bit(1);
    send_bit(1);
    send_bit(0);
    rx = 0;
    repeat (BIT / 2) @(negedge clk);
    check("mid_frame_busy", busy, 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    rx = 1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", rx_valid, 0);
    check("rst_mid_err", frame_err, 0);
    check("rst_mid_data", rx_data, 0);
    idle(12);
    push(0, 8'h3C);
    send(8'h3C, 1);
    idle(2);
    push(1, 8'h3C);
    rx = 0;
    repeat (20 * BIT) @(negedge clk);
    idle(2);
    check("break_idle_busy", busy, 0);
    push(0, 8'h81);
    send(8'h81, 1);
    idle(3);
    check("pulse_count", seen, pushed);
    check("queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
